demux_8bit_reg: RTL

//   Registered 1:2 demultiplexer; the distributing counterpart of the 8-bit 2:1 selector.

---
 rtl/demux_8bit_reg_if.sv | 33 +++
 rtl/demux_8bit_reg.sv | 92 +++++++++
 2 files changed

// File: rtl/demux_8bit_reg_if.sv
// Producer/consumer bus of the registered 1:2 demultiplexer.
// "master" is the environment side, "slave" is the demultiplexer itself.
interface demux_8bit_reg_if #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4
);
    logic [WIDTH-1:0]     in_data;
    logic                 in_sel;
    logic                 in_valid;
    logic                 in_ready;

    logic [WIDTH-1:0]     out0_data;
    logic                 out0_valid;
    logic                 out0_ready;
    logic [WIDTH-1:0]     out1_data;
    logic                 out1_valid;
    logic                 out1_ready;

    logic [CNT_WIDTH-1:0] out0_count;
    logic [CNT_WIDTH-1:0] out1_count;

    modport master (
        output in_data, in_sel, in_valid, out0_ready, out1_ready,
        input  in_ready, out0_data, out0_valid, out1_data, out1_valid,
        input  out0_count, out1_count
    );

    modport slave (
        input  in_data, in_sel, in_valid, out0_ready, out1_ready,
        output in_ready, out0_data, out0_valid, out1_data, out1_valid,
        output out0_count, out1_count
    );
endinterface

// File: rtl/demux_8bit_reg.sv
// Registered 1:2 demultiplexer: routes each input word to one of two channels,
// each with a one-entry holding register, valid/ready handshake and delivery counter.
module demux_8bit_reg #(
    parameter int WIDTH     = 8,
    parameter int CNT_WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    demux_8bit_reg_if.slave   bus
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } ch_state_t;

    logic       in_ready_int;
    logic [1:0] ch_out_ready;

    assign ch_out_ready = {bus.out1_ready, bus.out0_ready};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : gen_ch
            localparam logic CH_SEL = (gi == 1) ? 1'b1 : 1'b0;

            ch_state_t            state_reg;
            ch_state_t            state_next;
            logic                 valid;
            logic                 acc;
            logic                 dlv;
            logic [WIDTH-1:0]     data_reg;
            logic [WIDTH-1:0]     data_next;
            logic [CNT_WIDTH-1:0] count_reg;
            logic [CNT_WIDTH-1:0] count_next;

            // Only the selected channel sees the producer; the other may drain freely.
            assign acc = bus.in_valid & in_ready_int & (bus.in_sel == CH_SEL);
            assign dlv = valid & ch_out_ready[gi];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state_reg <= EMPTY;
                end else begin
                    state_reg <= state_next;
                end
            end

            always_comb begin
                state_next = state_reg;
                case (state_reg)
                    EMPTY:   if (acc)         state_next = FULL;
                    FULL:    if (dlv && !acc) state_next = EMPTY;
                    default:                  state_next = EMPTY;
                endcase
            end

            always_comb begin
                valid = (state_reg == FULL);
            end

            // Data only changes on acceptance, so a drained channel keeps its last word.
            always_comb begin
                data_next  = acc ? bus.in_data : data_reg;
                count_next = dlv ? count_reg + 1'b1 : count_reg;
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    data_reg  <= '0;
                    count_reg <= '0;
                end else begin
                    data_reg  <= data_next;
                    count_reg <= count_next;
                end
            end
        end
    endgenerate

    // A full channel can still take a word in the cycle its consumer drains it.
    assign in_ready_int = bus.in_sel ? (~gen_ch[1].valid | bus.out1_ready)
                                     : (~gen_ch[0].valid | bus.out0_ready);

    assign bus.in_ready   = in_ready_int;
    assign bus.out0_data  = gen_ch[0].data_reg;
    assign bus.out0_valid = gen_ch[0].valid;
    assign bus.out0_count = gen_ch[0].count_reg;
    assign bus.out1_data  = gen_ch[1].data_reg;
    assign bus.out1_valid = gen_ch[1].valid;
    assign bus.out1_count = gen_ch[1].count_reg;

endmodule
